// File: rtl/ay_seq_pkg.sv
// Shared types and constants for the AY-3-8913 frame-locked register write sequencer.
package ay_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } seq_state_e;

    localparam int unsigned ENTRY_W  = 13;
    localparam int unsigned WAIT_BIT = 12;
    localparam int unsigned REG_MSB  = 11;
    localparam int unsigned REG_LSB  = 8;

    // 64 MHz / 50 Hz
    localparam int unsigned DEFAULT_FRAME_DIV = 1280000;

    // A zero-frame marker still waits for the next tick.
    function automatic logic [7:0] wait_frames(logic [7:0] count);
        return (count == 8'd0) ? 8'd1 : count;
    endfunction

endpackage

// File: rtl/ay_seq_fifo.sv
// Synchronous FIFO with flush; combinational head read, registered full/empty/level.
module ay_seq_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 13
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [LW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == LW'(DEPTH));
    assign empty   = (count_q == '0);
    assign level   = count_q;
    assign rdata   = mem_q[rptr_q];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + LW'(1);
                2'b01:   count_q <= count_q - LW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ay_frame_sequencer.sv
// Frame-locked scheduler that drains queued PSG register writes one per clock and
// stalls on "wait N frames" markers until N frame ticks have elapsed.
module ay_frame_sequencer
    import ay_seq_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned FRAME_DIV = DEFAULT_FRAME_DIV,
    parameter int unsigned DIV_W     = 21
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   flush,
    input  logic                   clr_starve,
    input  logic                   host_valid,
    output logic                   host_ready,
    input  logic                   host_wait,
    input  logic [3:0]             host_reg,
    input  logic [7:0]             host_data,
    output logic                   psg_write,
    output logic [3:0]             psg_reg,
    output logic [7:0]             psg_data,
    output logic                   frame_tick,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy,
    output logic                   starve
);

    logic               fifo_full, fifo_empty, fifo_pop;
    logic [ENTRY_W-1:0] head;

    ay_seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (host_valid && host_ready),
        .wdata ({host_wait, host_reg, host_data}),
        .pop   (fifo_pop),
        .rdata (head),
        .flush (flush),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign host_ready = !fifo_full;

    logic [DIV_W-1:0] div_q;
    logic             tick_q;
    logic             div_wrap;

    assign div_wrap = (div_q == DIV_W'(FRAME_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else if (enable) begin
            div_q  <= div_wrap ? '0 : div_q + DIV_W'(1);
            tick_q <= div_wrap;
        end else begin
            tick_q <= 1'b0;
        end
    end

    seq_state_e state_q, state_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic [3:0] reg_q, reg_d;
    logic [7:0] data_q, data_d;
    logic       starve_q, starve_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            wcnt_q   <= '0;
            reg_q    <= '0;
            data_q   <= '0;
            starve_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            reg_q    <= reg_d;
            data_q   <= data_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        reg_d    = reg_q;
        data_d   = data_q;
        fifo_pop = 1'b0;
        if (flush) begin
            state_d = StIdle;
            wcnt_d  = '0;
        end else begin
            case (state_q)
                StIdle, StIssue: begin
                    // ISSUE can chain straight into the next entry for 1 write per clock.
                    state_d = StIdle;
                    if (enable && !fifo_empty) begin
                        fifo_pop = 1'b1;
                        if (head[WAIT_BIT]) begin
                            state_d = StWait;
                            wcnt_d  = wait_frames(head[REG_LSB-1:0]);
                        end else begin
                            state_d = StIssue;
                            reg_d   = head[REG_MSB:REG_LSB];
                            data_d  = head[REG_LSB-1:0];
                        end
                    end
                end
                StWait: begin
                    if (enable && tick_q) begin
                        if (wcnt_q == 8'd1) begin
                            state_d = StIdle;
                            wcnt_d  = '0;
                        end else begin
                            wcnt_d = wcnt_q - 8'd1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Underrun takes precedence over a same-cycle clear.
    always_comb begin
        starve_d = starve_q;
        if (tick_q && (state_q == StIdle) && fifo_empty) begin
            starve_d = 1'b1;
        end else if (clr_starve) begin
            starve_d = 1'b0;
        end
    end

    assign psg_write  = (state_q == StIssue);
    assign psg_reg    = reg_q;
    assign psg_data   = data_q;
    assign frame_tick = tick_q;
    assign busy       = !fifo_empty || (state_q == StWait);
    assign starve     = starve_q;

endmodule
